// File: rtl/pe_graph_top.sv
// pe_graph_top
// -----------------------------------------------------------------------------
// Two-PE dataflow tile: a multiplier PE (a*b) and an adder PE (c+d), each
// with a one-entry result register, feeding a combinational 2x2 output
// switch (sw0) steered by a live route table.
//
// Handshake rule, used on every stream: a word moves on a rising clock edge
// where both valid and ready are high. Valid never depends on ready. Ready
// may depend on valid: each operand's ready needs its partner operand to be
// valid, because a PE consumes both operands together.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   a_*/b_*                        multiplier operand streams (32-bit)
//   c_*/d_*                        adder operand streams (32-bit)
//   out0_*/out1_*                  switch output streams (32-bit)
//   sw0_cfg_route_table[3:0]       bit 2*o+i set: output o takes switch input i
//                                  (input 0 = multiplier, input 1 = adder)
//   error_valid, error_code[15:0]  sticky configuration error report
//
// Build option
//   PE_GRAPH_TOP_ERRCHK_EN  defined: rows with both bits set are flagged
//                           (code 16'h0001), drive valid 0 and never drain.
//                           undefined: error outputs are tied to 0 and a
//                           multi-hot row selects the multiplier.
// -----------------------------------------------------------------------------
module pe_graph_top (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [31:0] b_data,
    input  logic        c_valid,
    output logic        c_ready,
    input  logic [31:0] c_data,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic [31:0] d_data,
    output logic        out0_valid,
    input  logic        out0_ready,
    output logic [31:0] out0_data,
    output logic        out1_valid,
    input  logic        out1_ready,
    output logic [31:0] out1_data,
    input  logic [3:0]  sw0_cfg_route_table,
    output logic        error_valid,
    output logic [15:0] error_code
);

    logic        mul_v, add_v;
    logic [31:0] mul_r, add_r;

    // Resolved per-output source selects; index is the output number.
    logic [1:0]  sel_mul, sel_add;
    logic [1:0]  out_rdy;

    logic        mul_drain, add_drain;
    logic        mul_free, add_free;
    logic        mul_fire, add_fire;

    assign out_rdy = {out1_ready, out0_ready};

`ifdef PE_GRAPH_TOP_ERRCHK_EN
    logic [1:0] row_bad;

    // A multi-hot row selects nothing, so it shows valid 0 and never
    // contributes to draining either PE.
    always_comb begin
        row_bad[0] = sw0_cfg_route_table[0] & sw0_cfg_route_table[1];
        row_bad[1] = sw0_cfg_route_table[2] & sw0_cfg_route_table[3];
        sel_mul[0] = sw0_cfg_route_table[0] & ~row_bad[0];
        sel_add[0] = sw0_cfg_route_table[1] & ~row_bad[0];
        sel_mul[1] = sw0_cfg_route_table[2] & ~row_bad[1];
        sel_add[1] = sw0_cfg_route_table[3] & ~row_bad[1];
    end

    logic        err_v;
    logic [15:0] err_code_r;

    // Sticky: only the first error code is kept until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_v      <= 1'b0;
            err_code_r <= 16'h0000;
        end else if (!err_v && (|row_bad)) begin
            err_v      <= 1'b1;
            err_code_r <= 16'h0001;
        end
    end

    assign error_valid = err_v;
    assign error_code  = err_code_r;
`else
    // Multi-hot rows fall back to input 0 (multiplier) by fixed priority.
    always_comb begin
        sel_mul[0] = sw0_cfg_route_table[0];
        sel_add[0] = sw0_cfg_route_table[1] & ~sw0_cfg_route_table[0];
        sel_mul[1] = sw0_cfg_route_table[2];
        sel_add[1] = sw0_cfg_route_table[3] & ~sw0_cfg_route_table[2];
    end

    assign error_valid = 1'b0;
    assign error_code  = 16'h0000;
`endif

    // A PE drains only when it is routed somewhere and every output that
    // selects it is ready in the same cycle (covers broadcast).
    assign mul_drain = mul_v & (|sel_mul) & (&(~sel_mul | out_rdy));
    assign add_drain = add_v & (|sel_add) & (&(~sel_add | out_rdy));

    // Free includes same-cycle drain, giving one result per cycle per PE.
    assign mul_free  = ~mul_v | mul_drain;
    assign add_free  = ~add_v | add_drain;

    assign a_ready   = b_valid & mul_free;
    assign b_ready   = a_valid & mul_free;
    assign c_ready   = d_valid & add_free;
    assign d_ready   = c_valid & add_free;

    assign mul_fire  = a_valid & b_valid & mul_free;
    assign add_fire  = c_valid & d_valid & add_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_v <= 1'b0;
            mul_r <= 32'h0;
        end else if (mul_fire) begin
            mul_v <= 1'b1;
            mul_r <= a_data * b_data;
        end else if (mul_drain) begin
            mul_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_v <= 1'b0;
            add_r <= 32'h0;
        end else if (add_fire) begin
            add_v <= 1'b1;
            add_r <= c_data + d_data;
        end else if (add_drain) begin
            add_v <= 1'b0;
        end
    end

    // Output switch: at most one select per row is set after resolution.
    always_comb begin
        out0_valid = (sel_mul[0] & mul_v) | (sel_add[0] & add_v);
        out1_valid = (sel_mul[1] & mul_v) | (sel_add[1] & add_v);
        out0_data  = 32'h0;
        out1_data  = 32'h0;
        if (sel_mul[0])      out0_data = mul_r;
        else if (sel_add[0]) out0_data = add_r;
        if (sel_mul[1])      out1_data = mul_r;
        else if (sel_add[1]) out1_data = add_r;
    end

endmodule

// File: tb/tb_pe_graph_top.sv
// tb_pe_graph_top
// -----------------------------------------------------------------------------
// Bench for pe_graph_top. A transaction-level reference keeps one queue of
// expected results per PE and derives readies, output valids/data and the
// error flag from the routing rules each cycle. Inputs change at the falling
// edge; outputs are sampled shortly after it, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_pe_graph_top;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 0, b_valid = 0, c_valid = 0, d_valid = 0;
    logic        a_ready, b_ready, c_ready, d_ready;
    logic [31:0] a_data = 0, b_data = 0, c_data = 0, d_data = 0;
    logic        out0_valid, out1_valid;
    logic        out0_ready = 0, out1_ready = 0;
    logic [31:0] out0_data, out1_data;
    logic [3:0]  tbl = 4'b1001;
    logic        error_valid;
    logic [15:0] error_code;

`ifdef PE_GRAPH_TOP_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    pe_graph_top dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data),
        .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
        .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
        .sw0_cfg_route_table(tbl),
        .error_valid(error_valid), .error_code(error_code)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [31:0] mul_q[$];
    logic [31:0] add_q[$];
    bit          err_m;
    bit          obs_cd_xfer;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Source feeding output o: 0 = multiplier, 1 = adder, -1 = nothing.
    function automatic int src_of(input logic [3:0] t, input int o);
        bit r0, r1;
        r0 = t[2*o];
        r1 = t[2*o+1];
        if (r0 && r1) return ERRCHK ? -1 : 0;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    function automatic bit pe_has(input int pe);
        return (pe == 0) ? (mul_q.size() > 0) : (pe == 1) ? (add_q.size() > 0) : 1'b0;
    endfunction

    function automatic logic [31:0] pe_front(input int pe);
        return (pe == 0) ? mul_q[0] : add_q[0];
    endfunction

    // Check one cycle against the reference, then advance through a rising
    // edge and return at the next falling edge.
    task automatic step();
        int s0, s1;
        bit ev0, ev1, mul_drain, add_drain, mul_free, add_free, mul_fire, add_fire, bad_now;
        logic [31:0] mul_res, add_res;
        #1;
        s0 = src_of(tbl, 0);
        s1 = src_of(tbl, 1);
        ev0 = pe_has(s0);
        ev1 = pe_has(s1);
        check("out0_valid", out0_valid, ev0);
        check("out1_valid", out1_valid, ev1);
        if (ev0) check("out0_data", out0_data, pe_front(s0));
        if (ev1) check("out1_data", out1_data, pe_front(s1));
        if (tbl[1:0] == 2'b00) check("out0_data_idle", out0_data, 32'h0);
        if (tbl[3:2] == 2'b00) check("out1_data_idle", out1_data, 32'h0);

        mul_drain = (mul_q.size() > 0) && (s0 == 0 || s1 == 0) &&
                    (s0 != 0 || out0_ready) && (s1 != 0 || out1_ready);
        add_drain = (add_q.size() > 0) && (s0 == 1 || s1 == 1) &&
                    (s0 != 1 || out0_ready) && (s1 != 1 || out1_ready);
        mul_free  = (mul_q.size() == 0) || mul_drain;
        add_free  = (add_q.size() == 0) || add_drain;
        check("a_ready", a_ready, b_valid & mul_free);
        check("b_ready", b_ready, a_valid & mul_free);
        check("c_ready", c_ready, d_valid & add_free);
        check("d_ready", d_ready, c_valid & add_free);
        check("error_valid", error_valid, err_m);
        check("error_code", error_code, err_m ? 32'h1 : 32'h0);

        mul_fire = a_valid && b_valid && mul_free;
        add_fire = c_valid && d_valid && add_free;
        mul_res  = a_data * b_data;
        add_res  = c_data + d_data;
        obs_cd_xfer = c_valid & c_ready & d_valid & d_ready;
        bad_now  = ERRCHK && (tbl[1:0] == 2'b11 || tbl[3:2] == 2'b11);

        @(posedge clk);
        if (mul_drain) void'(mul_q.pop_front());
        if (add_drain) void'(add_q.pop_front());
        if (mul_fire) mul_q.push_back(mul_res);
        if (add_fire) add_q.push_back(add_res);
        if (bad_now) err_m = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        a_valid = 0; b_valid = 0; c_valid = 0; d_valid = 0;
    endtask

    // Asynchronous reset pulse starting in the low phase of the clock.
    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        mul_q.delete();
        add_q.delete();
        err_m = 1'b0;
        check("rst_out0_valid", out0_valid, 0);
        check("rst_out1_valid", out1_valid, 0);
        check("rst_error_valid", error_valid, 0);
        check("rst_error_code", error_code, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0] tbl_pool[12] = '{4'b1001, 4'b0110, 4'b0101, 4'b1010, 4'b1001, 4'b0110,
                                 4'b0001, 4'b0100, 4'b1000, 4'b0011, 4'b1111, 4'b1101};

    initial begin
        bit got;
        @(negedge clk);
        do_reset();

        // 1: idle after reset
        step();
        #1;
        check("t1_err", error_valid, 0);
        check("t1_v0", out0_valid, 0);
        check("t1_v1", out1_valid, 0);

        // 2: table 1001, all four operands together
        tbl = 4'b1001; out0_ready = 1; out1_ready = 1;
        a_valid = 1; a_data = 3; b_valid = 1; b_data = 4;
        c_valid = 1; c_data = 5; d_valid = 1; d_data = 6;
        step();
        idle_inputs();
        #1;
        check("t2_out0", out0_data, 32'd12);
        check("t2_out1", out1_data, 32'd11);
        step();
        check("t2_err", error_valid, 0);

        // 3: table 0110 swaps the routes
        tbl = 4'b0110;
        a_valid = 1; a_data = 2; b_valid = 1; b_data = 8;
        c_valid = 1; c_data = 3; d_valid = 1; d_data = 7;
        step();
        idle_inputs();
        #1;
        check("t3_out0", out0_data, 32'd10);
        check("t3_out1", out1_data, 32'd16);
        step();

        // 4: adder alone while out0 is stalled
        do_reset();
        tbl = 4'b1001; out0_ready = 0; out1_ready = 0;
        c_valid = 1; c_data = 4; d_valid = 1; d_data = 5;
        got = 0;
        for (int i = 0; i < 80 && !got; i++) begin
            step();
            got = obs_cd_xfer;
        end
        check("t4_cd_handshake", got, 1);
        idle_inputs();
        #1;
        check("t4_out1", out1_data, 32'd9);
        check("t4_out1_v", out1_valid, 1);
        for (int i = 0; i < 8; i++) begin
            step();
            check("t4_out0_quiet", out0_valid, 0);
        end
        out1_ready = 1;
        step();

        // 5: multi-source row
        tbl = 4'b0011;
        step();
        #1;
        check("t5_err_v", error_valid, ERRCHK);
        check("t5_err_code", error_code, ERRCHK ? 32'h1 : 32'h0);
        tbl = 4'b1001;
        step();
        step();
        check("t5_err_sticky", error_valid, ERRCHK);
        do_reset();
        check("t5_err_clr", error_valid, 0);

        // 6: multiplier broadcast with out1 stalled
        tbl = 4'b0101; out0_ready = 1; out1_ready = 0;
        a_valid = 1; a_data = 7; b_valid = 1; b_data = 9;
        step();
        a_valid = 0;
        for (int i = 0; i < 3; i++) step();
        #1;
        check("t6_out0", out0_data, 32'd63);
        check("t6_out1", out1_data, 32'd63);
        check("t6_hold_a_ready", a_ready, 0);
        out1_ready = 1;
        #1;
        check("t6_drain_a_ready", a_ready, 1);
        step();
        check("t6_drained", out1_valid, 0);
        b_valid = 0;

        // Random traffic with occasional table changes and resets
        tbl = 4'b1001;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                if (mul_q.size() == 0 && add_q.size() == 0 && $urandom_range(0, 7) == 0)
                    tbl = tbl_pool[$urandom_range(0, 11)];
                a_valid = ($urandom_range(0, 3) != 0);
                b_valid = ($urandom_range(0, 3) != 0);
                c_valid = ($urandom_range(0, 3) != 0);
                d_valid = ($urandom_range(0, 3) != 0);
                a_data = $urandom; b_data = $urandom;
                c_data = $urandom; d_data = $urandom;
                out0_ready = ($urandom_range(0, 2) != 0);
                out1_ready = ($urandom_range(0, 2) != 0);
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
